// File: rtl/vga_rect_fill_if.sv
// Command and framebuffer-write bundle for vga_rect_fill.
// The slave modport is the fill engine; the master modport is the command source and write port.
interface vga_rect_fill_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [15:0] cmd_color;
  logic [16:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        wr_stall;
  logic        busy;
  logic        done;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, wr_stall,
    input  cmd_ready, wr_addr, wr_data, wr_en, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, wr_stall,
    output cmd_ready, wr_addr, wr_data, wr_en, busy, done
  );
endinterface

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: writes one RGB565 pixel per cycle, row-major, into a linear framebuffer.
// Define VGA_RECT_FILL_CLIP_EN to clip rectangles to the framebuffer; otherwise addresses wrap.
module vga_rect_fill #(
  parameter int unsigned FB_WIDTH  = 400,
  parameter int unsigned FB_HEIGHT = 240
) (
  input logic           vgaclock,
  input logic           reset,
  vga_rect_fill_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StClip = 2'd1;
  localparam logic [1:0] StDraw = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [8:0]  x_q, w_q;
  logic [7:0]  y_q, h_q;
  logic [15:0] color_q;
  logic [16:0] addr_q, base_q;
  logic [15:0] data_q;
  logic [8:0]  cols_left_q;
  logic [7:0]  rows_left_q;

  logic [8:0]  eff_w;
  logic [7:0]  eff_h;
  logic [16:0] start_addr;
  logic [16:0] next_base;
  logic        handshake;
  logic        consume;
  logic        row_end;
  logic        last_pix;
  logic        enter_draw;

`ifdef VGA_RECT_FILL_CLIP_EN
  logic [9:0] room_w;
  logic [8:0] room_h;

  always_comb begin
    room_w = 10'(FB_WIDTH) - {1'b0, x_q};
    room_h = 9'(FB_HEIGHT) - {1'b0, y_q};
    eff_w  = '0;
    eff_h  = '0;
    if (32'(x_q) < FB_WIDTH && 32'(y_q) < FB_HEIGHT) begin
      eff_w = ({1'b0, w_q} < room_w) ? w_q : room_w[8:0];
      eff_h = ({1'b0, h_q} < room_h) ? h_q : room_h[7:0];
    end
  end
`else
  always_comb begin
    eff_w = w_q;
    eff_h = h_q;
  end
`endif

  // The only multiply happens once per command; the pixel path just adds.
  assign start_addr = 17'(y_q) * 17'(FB_WIDTH) + 17'(x_q);
  assign next_base  = base_q + 17'(FB_WIDTH);

  assign handshake  = (state_q == StIdle) && bus.cmd_valid;
  assign consume    = (state_q == StDraw) && !bus.wr_stall;
  assign row_end    = (cols_left_q == 9'd1);
  assign last_pix   = row_end && (rows_left_q == 8'd1);
  assign enter_draw = (state_q == StClip) && (eff_w != 9'd0) && (eff_h != 8'd0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.cmd_valid) state_d = StClip;
      StClip:  state_d = enter_draw ? StDraw : StDone;
      StDraw:  if (consume && last_pix) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge vgaclock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      addr_q      <= '0;
      base_q      <= '0;
      data_q      <= '0;
      cols_left_q <= '0;
      rows_left_q <= '0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        x_q     <= bus.cmd_x;
        y_q     <= bus.cmd_y;
        w_q     <= bus.cmd_w;
        h_q     <= bus.cmd_h;
        color_q <= bus.cmd_color;
      end
      // Write-port outputs only move on DRAW entry or on a consumed pixel.
      if (enter_draw) begin
        addr_q      <= start_addr;
        base_q      <= start_addr;
        data_q      <= color_q;
        cols_left_q <= eff_w;
        rows_left_q <= eff_h;
      end else if (consume) begin
        if (row_end) begin
          base_q      <= next_base;
          addr_q      <= next_base;
          cols_left_q <= eff_w;
          rows_left_q <= rows_left_q - 8'd1;
        end else begin
          addr_q      <= addr_q + 17'd1;
          cols_left_q <= cols_left_q - 9'd1;
        end
      end
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.wr_en     = (state_q == StDraw);
  assign bus.busy      = (state_q == StClip) || (state_q == StDraw);
  assign bus.done      = (state_q == StDone);
  assign bus.wr_addr   = addr_q;
  assign bus.wr_data   = data_q;

endmodule

// File: doc/vga_rect_fill.md
VGA_RECT_FILL -- requirements
Module: vga_rect_fill

Interface
REQ-001 Parameter FB_WIDTH, default 400, framebuffer pixels per row.
REQ-002 Parameter FB_HEIGHT, default 240, framebuffer rows.
REQ-003 vgaclock  input  1  clock; all logic rises on posedge vgaclock.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  fill command present.
REQ-006 cmd_ready  output  1  block accepts a command this cycle.
REQ-007 cmd_x  input  9  left column, 0..FB_WIDTH-1.
REQ-008 cmd_y  input  8  top row, 0..FB_HEIGHT-1.
REQ-009 cmd_w  input  9  rectangle width in pixels.
REQ-010 cmd_h  input  8  rectangle height in pixels.
REQ-011 cmd_color  input  16  fill colour, RGB565 (R[15:11], G[10:5], B[4:0]).
REQ-012 wr_addr  output  17  framebuffer word address, y*FB_WIDTH + x.
REQ-013 wr_data  output  16  pixel written.
REQ-014 wr_en  output  1  write strobe to framebuffer write port.
REQ-015 wr_stall  input  1  write port busy; current write not taken.
REQ-016 busy  output  1  command in progress.
REQ-017 done  output  1  one-cycle pulse at command completion.

Function
REQ-018 FSM states IDLE, CLIP, DRAW, DONE; reset state IDLE.
REQ-019 cmd_ready SHALL be 1 exactly in IDLE; handshake occurs when cmd_valid && cmd_ready; all cmd_* fields registered on that edge.
REQ-020 IDLE -> CLIP on handshake; CLIP lasts one cycle computing effective width/height, start address and row base.
REQ-021 CLIP -> DRAW if effective width and height both nonzero, else CLIP -> DONE.
REQ-022 In DRAW, wr_en SHALL be 1 every cycle; first wr_en at handshake cycle N+2.
REQ-023 Pixel order row-major: left to right, then top to bottom; wr_data = registered cmd_color for every pixel.
REQ-024 Address generated incrementally: +1 per pixel within a row; at row end, row base += FB_WIDTH and wr_addr = new row base; no multiplier in the per-pixel path.
REQ-025 A pixel is consumed on a cycle with wr_en=1 and wr_stall=0; while wr_stall=1, wr_addr, wr_data and wr_en SHALL hold unchanged.
REQ-026 DRAW -> DONE on the cycle the last pixel is consumed; DONE lasts one cycle, done=1, then -> IDLE.
REQ-027 busy = 1 in CLIP and DRAW, 0 in IDLE and DONE.
REQ-028 Outside DRAW, wr_en = 0; wr_addr/wr_data hold last value.
REQ-029 cmd_valid held high through a command is ignored until IDLE; back-to-back commands: next handshake on the cycle after DONE.
REQ-030 Address arithmetic 17-bit unsigned; wrap modulo 2^17 without error.

Reset
REQ-031 On reset assertion, asynchronously: state IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0; cmd_ready=1 from the first cycle with reset deasserted.
REQ-032 Reset mid-command aborts it; no further writes for that command.

Configuration
REQ-033 Macro VGA_RECT_FILL_CLIP_EN defined: in CLIP, if cmd_x>=FB_WIDTH or cmd_y>=FB_HEIGHT, effective size is 0; else effective width = min(cmd_w, FB_WIDTH-cmd_x), effective height = min(cmd_h, FB_HEIGHT-cmd_y).
REQ-034 Macro undefined: effective size = cmd_w x cmd_h unmodified; out-of-range pixels wrap per REQ-024/REQ-030.

Verification
REQ-035 x=10,y=5,w=3,h=2,color=16'hF800, no stall -> wr_addr 2010,2011,2012,2410,2411,2412 on cycles N+2..N+7, wr_data=F800, done=1 at N+8.
REQ-036 Same command, wr_stall=1 for 3 cycles while wr_addr=2011 -> 2011 held 4 cycles, no pixel skipped/duplicated, done at N+11.
REQ-037 x=398,y=239,w=5,h=4, CLIP_EN defined -> exactly two writes 95998, 95999, then done; CLIP_EN undefined -> 20 writes starting 95998.
REQ-038 w=0,h=7 -> no wr_en, busy=1 at N+1 only, done=1 at N+2, cmd_ready=1 at N+3.
REQ-039 Reset asserted during DRAW of a 10x10 fill -> wr_en=0 immediately, no write after release, cmd_ready=1 first cycle after release.
REQ-040 cmd_valid held high with two queued 1x1 commands -> second handshake on cycle after first done; writes at N+2 and N+6.
